// File: rtl/saturn_bus_ctrl.sv
// Nibble-serial memory bus controller for a Saturn-style core: owns the PC and
// DP pointers, sequences reads, writes and 5-nibble pointer loads.
module saturn_bus_ctrl #(
    parameter logic [19:0] PC_RESET = 20'h00000,
    parameter logic [19:0] DP_RESET = 20'h00000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en_bus_send,
    input  logic        i_en_bus_recv,
    input  logic [2:0]  i_cmd,
    input  logic        i_cmd_valid,
    input  logic [3:0]  i_nibble,
    output logic [3:0]  o_nibble,
    output logic        o_nibble_valid,
    output logic        o_busy,
    output logic        o_bus_error,
    output logic [19:0] o_mem_addr,
    output logic        o_mem_re,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_wdata,
    input  logic [3:0]  i_mem_rdata,
    output logic [19:0] o_pc_ptr,
    output logic [19:0] o_dp_ptr,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [2:0] CMD_NOP      = 3'd0;
    localparam logic [2:0] CMD_PC_READ  = 3'd1;
    localparam logic [2:0] CMD_DP_READ  = 3'd2;
    localparam logic [2:0] CMD_DP_WRITE = 3'd3;
    localparam logic [2:0] CMD_LOAD_PC  = 3'd4;
    localparam logic [2:0] CMD_LOAD_DP  = 3'd5;

    // Handshake: a command is taken only when i_en_bus_send and i_cmd_valid are
    // both high on an edge where the FSM is IDLE; read data is taken on the
    // first i_en_bus_recv edge while in READ.

    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic [19:0] load_addr, load_addr_n;
    logic        load_dp, load_dp_n;     // 0: LOAD_PC target, 1: LOAD_DP target
    logic        read_dp, read_dp_n;     // 0: PC_READ pending, 1: DP_READ pending
    logic [19:0] pc, pc_n, dp, dp_n;
    logic [3:0]  nibble_n;
    logic        nibble_valid_n;
    logic        bus_error_n;
    logic [19:0] mem_addr_n;
    logic        mem_re_n, mem_we_n;
    logic [3:0]  mem_wdata_n;
    logic [19:0] assembled;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state          <= IDLE;
            cnt            <= 3'd0;
            load_addr      <= 20'h00000;
            load_dp        <= 1'b0;
            read_dp        <= 1'b0;
            pc             <= PC_RESET;
            dp             <= DP_RESET;
            o_nibble       <= 4'h0;
            o_nibble_valid <= 1'b0;
            o_bus_error    <= 1'b0;
            o_mem_addr     <= 20'h00000;
            o_mem_re       <= 1'b0;
            o_mem_we       <= 1'b0;
            o_mem_wdata    <= 4'h0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            load_addr      <= load_addr_n;
            load_dp        <= load_dp_n;
            read_dp        <= read_dp_n;
            pc             <= pc_n;
            dp             <= dp_n;
            o_nibble       <= nibble_n;
            o_nibble_valid <= nibble_valid_n;
            o_bus_error    <= bus_error_n;
            o_mem_addr     <= mem_addr_n;
            o_mem_re       <= mem_re_n;
            o_mem_we       <= mem_we_n;
            o_mem_wdata    <= mem_wdata_n;
        end
    end

    // The incoming nibble merged into the partial address at slot cnt.
    always_comb begin
        assembled = load_addr;
        case (cnt)
            3'd1:    assembled[7:4]   = i_nibble;
            3'd2:    assembled[11:8]  = i_nibble;
            3'd3:    assembled[15:12] = i_nibble;
            3'd4:    assembled[19:16] = i_nibble;
            default: assembled[3:0]   = i_nibble;
        endcase
    end

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        load_addr_n    = load_addr;
        load_dp_n      = load_dp;
        read_dp_n      = read_dp;
        pc_n           = pc;
        dp_n           = dp;
        nibble_n       = o_nibble;
        nibble_valid_n = 1'b0;
        bus_error_n    = o_bus_error;
        mem_addr_n     = o_mem_addr;
        mem_re_n       = 1'b0;
        mem_we_n       = 1'b0;
        mem_wdata_n    = o_mem_wdata;

        case (state)
            IDLE: begin
                if (i_en_bus_send && i_cmd_valid) begin
                    case (i_cmd)
                        CMD_NOP: ;
                        CMD_PC_READ, CMD_DP_READ: begin
                            read_dp_n  = (i_cmd == CMD_DP_READ);
                            mem_addr_n = (i_cmd == CMD_DP_READ) ? dp : pc;
                            mem_re_n   = 1'b1;
                            state_n    = READ;
                        end
                        CMD_DP_WRITE: begin
                            mem_addr_n  = dp;
                            mem_wdata_n = i_nibble;
                            mem_we_n    = 1'b1;
                            dp_n        = dp + 20'd1;
                        end
                        CMD_LOAD_PC, CMD_LOAD_DP: begin
                            load_dp_n   = (i_cmd == CMD_LOAD_DP);
                            load_addr_n = {16'h0000, i_nibble};
                            cnt_n       = 3'd1;
                            state_n     = LOAD;
                        end
                        default: bus_error_n = 1'b1;
                    endcase
                end
            end
            READ: begin
                // Send-side commands are refused here even when recv retires the read.
                if (i_en_bus_send && i_cmd_valid)
                    bus_error_n = 1'b1;
                if (i_en_bus_recv) begin
                    nibble_n       = i_mem_rdata;
                    nibble_valid_n = 1'b1;
                    if (read_dp)
                        dp_n = dp + 20'd1;
                    else
                        pc_n = pc + 20'd1;
                    state_n = IDLE;
                end
            end
            LOAD: begin
                if (i_en_bus_send) begin
                    load_addr_n = assembled;
                    cnt_n       = cnt + 3'd1;
                    if (cnt == 3'd4) begin
                        if (load_dp)
                            dp_n = assembled;
                        else
                            pc_n = assembled;
                        cnt_n   = 3'd0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign o_busy      = (state != IDLE);
    assign o_pc_ptr    = pc;
    assign o_dp_ptr    = dp;
    assign o_dbg_state = state;

endmodule

// File: tb/tb_saturn_bus_ctrl.sv
// Directed bench for saturn_bus_ctrl: a vector table for the main command
// flows plus hand-written reset-during-transaction sequences.
module tb_saturn_bus_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en_send, en_recv, cmd_valid;
    logic [2:0]  cmd;
    logic [3:0]  nib_in;
    logic [3:0]  nibble;
    logic        nibble_valid, busy, bus_error;
    logic [19:0] mem_addr;
    logic        mem_re, mem_we;
    logic [3:0]  mem_wdata;
    logic [3:0]  mem_rdata;
    logic [19:0] pc_ptr, dp_ptr;
    logic [1:0]  dbg_state;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic        s, r, v;
        logic [2:0]  cmd;
        logic [3:0]  nib;
        logic        busy, re, we, val;
        logic [3:0]  onib;
        logic [19:0] addr, pc, dp;
        logic        err;
        logic [3:0]  wdata;
    } vec_t;

    vec_t vecs[$];

    saturn_bus_ctrl #(.PC_RESET(20'h00000), .DP_RESET(20'h00000)) dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_en_bus_send  (en_send),
        .i_en_bus_recv  (en_recv),
        .i_cmd          (cmd),
        .i_cmd_valid    (cmd_valid),
        .i_nibble       (nib_in),
        .o_nibble       (nibble),
        .o_nibble_valid (nibble_valid),
        .o_busy         (busy),
        .o_bus_error    (bus_error),
        .o_mem_addr     (mem_addr),
        .o_mem_re       (mem_re),
        .o_mem_we       (mem_we),
        .o_mem_wdata    (mem_wdata),
        .i_mem_rdata    (mem_rdata),
        .o_pc_ptr       (pc_ptr),
        .o_dp_ptr       (dp_ptr),
        .o_dbg_state    (dbg_state)
    );

    // Clock / memory model: read data is the address low nibble XOR A,
    // presented the cycle after the read strobe.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_re) mem_rdata <= mem_addr[3:0] ^ 4'hA;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic s, input logic r, input logic v,
                         input logic [2:0] c, input logic [3:0] n);
        en_send = s; en_recv = r; cmd_valid = v; cmd = c; nib_in = n;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic r, input logic v, input logic [2:0] c,
                       input logic [3:0] n, input logic b, input logic re, input logic we,
                       input logic val, input logic [3:0] onib, input logic [19:0] addr,
                       input logic [19:0] pc, input logic [19:0] dp, input logic err,
                       input logic [3:0] wd);
        vec_t t;
        t.s = s; t.r = r; t.v = v; t.cmd = c; t.nib = n;
        t.busy = b; t.re = re; t.we = we; t.val = val; t.onib = onib;
        t.addr = addr; t.pc = pc; t.dp = dp; t.err = err; t.wdata = wd;
        vecs.push_back(t);
    endtask

    initial begin
        //   s r v cmd nib  busy re we val onib addr      pc        dp        err wd
        // PC_READ from address 0
        add(1,0,1,1,4'h0, 1,1,0,0,4'h0,20'h00000,20'h00000,20'h00000,0,4'h0);
        add(0,0,0,0,4'h0, 1,0,0,0,4'h0,20'h00000,20'h00000,20'h00000,0,4'h0);
        add(0,1,0,0,4'h0, 0,0,0,1,4'hA,20'h00000,20'h00001,20'h00000,0,4'h0);
        add(0,0,0,0,4'h0, 0,0,0,0,4'hA,20'h00000,20'h00001,20'h00000,0,4'h0);
        // LOAD_PC 12345; recv and cmd_valid during LOAD are ignored
        add(1,0,1,4,4'h5, 1,0,0,0,4'hA,20'h00000,20'h00001,20'h00000,0,4'h0);
        add(1,1,0,0,4'h4, 1,0,0,0,4'hA,20'h00000,20'h00001,20'h00000,0,4'h0);
        add(1,0,1,0,4'h3, 1,0,0,0,4'hA,20'h00000,20'h00001,20'h00000,0,4'h0);
        add(1,0,0,0,4'h2, 1,0,0,0,4'hA,20'h00000,20'h00001,20'h00000,0,4'h0);
        add(1,0,0,0,4'h1, 0,0,0,0,4'hA,20'h00000,20'h12345,20'h00000,0,4'h0);
        // PC_READ at 12345
        add(1,0,1,1,4'h0, 1,1,0,0,4'hA,20'h12345,20'h12345,20'h00000,0,4'h0);
        add(0,0,0,0,4'h0, 1,0,0,0,4'hA,20'h12345,20'h12345,20'h00000,0,4'h0);
        add(0,1,0,0,4'h0, 0,0,0,1,4'hF,20'h12345,20'h12346,20'h00000,0,4'h0);
        // LOAD_DP FFFFF, then two writes wrapping DP
        add(1,0,1,5,4'hF, 1,0,0,0,4'hF,20'h12345,20'h12346,20'h00000,0,4'h0);
        add(1,0,0,0,4'hF, 1,0,0,0,4'hF,20'h12345,20'h12346,20'h00000,0,4'h0);
        add(1,0,0,0,4'hF, 1,0,0,0,4'hF,20'h12345,20'h12346,20'h00000,0,4'h0);
        add(1,0,0,0,4'hF, 1,0,0,0,4'hF,20'h12345,20'h12346,20'h00000,0,4'h0);
        add(1,0,0,0,4'hF, 0,0,0,0,4'hF,20'h12345,20'h12346,20'hFFFFF,0,4'h0);
        add(1,0,1,3,4'h7, 0,0,1,0,4'hF,20'hFFFFF,20'h12346,20'h00000,0,4'h7);
        add(1,0,1,3,4'h8, 0,0,1,0,4'hF,20'h00000,20'h12346,20'h00001,0,4'h8);
        // DP_READ, command while busy, then send+recv together
        add(1,0,1,2,4'h0, 1,1,0,0,4'hF,20'h00001,20'h12346,20'h00001,0,4'h8);
        add(1,0,1,3,4'h9, 1,0,0,0,4'hF,20'h00001,20'h12346,20'h00001,1,4'h8);
        add(1,1,1,3,4'h9, 0,0,0,1,4'hB,20'h00001,20'h12346,20'h00002,1,4'h8);
        // illegal 6, recv in IDLE, NOP, illegal 7: nothing moves, error sticky
        add(1,0,1,6,4'h0, 0,0,0,0,4'hB,20'h00001,20'h12346,20'h00002,1,4'h8);
        add(0,1,0,0,4'h0, 0,0,0,0,4'hB,20'h00001,20'h12346,20'h00002,1,4'h8);
        add(1,0,1,0,4'h0, 0,0,0,0,4'hB,20'h00001,20'h12346,20'h00002,1,4'h8);
        add(1,0,1,7,4'h0, 0,0,0,0,4'hB,20'h00001,20'h12346,20'h00002,1,4'h8);
        // LOAD_PC FFFFF, PC_READ wraps PC to 00000
        add(1,0,1,4,4'hF, 1,0,0,0,4'hB,20'h00001,20'h12346,20'h00002,1,4'h8);
        add(1,0,0,0,4'hF, 1,0,0,0,4'hB,20'h00001,20'h12346,20'h00002,1,4'h8);
        add(1,0,0,0,4'hF, 1,0,0,0,4'hB,20'h00001,20'h12346,20'h00002,1,4'h8);
        add(1,0,0,0,4'hF, 1,0,0,0,4'hB,20'h00001,20'h12346,20'h00002,1,4'h8);
        add(1,0,0,0,4'hF, 0,0,0,0,4'hB,20'h00001,20'hFFFFF,20'h00002,1,4'h8);
        add(1,0,1,1,4'h0, 1,1,0,0,4'hB,20'hFFFFF,20'hFFFFF,20'h00002,1,4'h8);
        add(0,0,0,0,4'h0, 1,0,0,0,4'hB,20'hFFFFF,20'hFFFFF,20'h00002,1,4'h8);
        add(0,1,0,0,4'h0, 0,0,0,1,4'h5,20'hFFFFF,20'h00000,20'h00002,1,4'h8);

        // Reset state
        rst_n = 1'b0; en_send = 0; en_recv = 0; cmd_valid = 0; cmd = 0; nib_in = 0;
        mem_rdata = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", pc_ptr, 20'h00000);
        chk("reset_dp", dp_ptr, 20'h00000);
        chk("reset_outs", {busy, bus_error, nibble_valid, mem_re, mem_we, nibble, mem_wdata},
            13'h0);
        chk("reset_addr", mem_addr, 20'h00000);
        chk("reset_state", dbg_state, 2'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].s, vecs[i].r, vecs[i].v, vecs[i].cmd, vecs[i].nib);
            chk($sformatf("v%0d_busy", i),  busy,         vecs[i].busy);
            chk($sformatf("v%0d_re", i),    mem_re,       vecs[i].re);
            chk($sformatf("v%0d_we", i),    mem_we,       vecs[i].we);
            chk($sformatf("v%0d_valid", i), nibble_valid, vecs[i].val);
            chk($sformatf("v%0d_nibble", i), nibble,      vecs[i].onib);
            chk($sformatf("v%0d_addr", i),  mem_addr,     vecs[i].addr);
            chk($sformatf("v%0d_pc", i),    pc_ptr,       vecs[i].pc);
            chk($sformatf("v%0d_dp", i),    dp_ptr,       vecs[i].dp);
            chk($sformatf("v%0d_err", i),   bus_error,    vecs[i].err);
            chk($sformatf("v%0d_wdata", i), mem_wdata,    vecs[i].wdata);
        end

        // Reset after the 3rd LOAD_PC nibble takes effect without a clock edge
        drive(1,0,1,4,4'h5);
        drive(1,0,0,0,4'h4);
        drive(1,0,0,0,4'h3);
        chk("load_busy", busy, 1'b1);
        drive(0,0,0,0,4'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_pc", pc_ptr, 20'h00000);
        chk("arst_err", bus_error, 1'b0);
        chk("arst_state", dbg_state, 2'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // First send after release is accepted
        drive(1,0,1,1,4'h0);
        chk("first_re", mem_re, 1'b1);
        chk("first_state", dbg_state, 2'd1);

        // Reset during READ drops the pending read
        #2 rst_n = 1'b0;
        #1;
        chk("rrst_busy", busy, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0,1,0,0,4'h0);
            chk($sformatf("rrst_novalid%0d", k), nibble_valid, 1'b0);
        end
        chk("rrst_pc", pc_ptr, 20'h00000);

        // A fresh load after the interrupted one starts from nibble 0
        drive(1,0,1,4,4'h1);
        drive(1,0,0,0,4'h2);
        drive(1,0,0,0,4'h3);
        drive(1,0,0,0,4'h4);
        chk("reload_busy", busy, 1'b1);
        drive(1,0,0,0,4'h5);
        chk("reload_pc", pc_ptr, 20'h54321);
        chk("reload_idle", busy, 1'b0);
        chk("reload_err", bus_error, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/saturn_bus_ctrl.md
SATURN_BUS_CTRL -- requirements
Module: saturn_bus_ctrl

Interface
REQ-001 Parameter PC_RESET, default 20'h00000, value loaded into the PC pointer at reset.
REQ-002 Parameter DP_RESET, default 20'h00000, value loaded into the DP pointer at reset.
REQ-003 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 i_reset  in  1  asynchronous, active-low reset.
REQ-005 i_en_bus_send  in  1  send-phase enable (phase 0 strobe from core clock generator).
REQ-006 i_en_bus_recv  in  1  receive-phase enable (phase 1 strobe).
REQ-007 i_cmd  in  3  command: 0 NOP, 1 PC_READ, 2 DP_READ, 3 DP_WRITE, 4 LOAD_PC, 5 LOAD_DP, 6-7 illegal.
REQ-008 i_cmd_valid  in  1  i_cmd qualifier.
REQ-009 i_nibble  in  4  write data / address nibble from core.
REQ-010 o_nibble  out  4  nibble read from memory, to decoder.
REQ-011 o_nibble_valid  out  1  one-cycle pulse, o_nibble updated.
REQ-012 o_busy  out  1  high while state is not IDLE.
REQ-013 o_bus_error  out  1  sticky protocol-error flag.
REQ-014 o_mem_addr  out  20  memory nibble address.
REQ-015 o_mem_re / o_mem_we  out  1 each  one-cycle read / write strobes.
REQ-016 o_mem_wdata  out  4  memory write data.
REQ-017 i_mem_rdata  in  4  memory read data, valid the cycle after o_mem_re.
REQ-018 o_pc_ptr / o_dp_ptr  out  20 each  current PC and DP pointers.

Function
REQ-019 States SHALL be IDLE, READ, LOAD; o_busy = (state != IDLE).
REQ-020 A command SHALL be accepted only on a cycle with i_en_bus_send & i_cmd_valid & state==IDLE; NOP accepted with no effect.
REQ-021 PC_READ/DP_READ accept: o_mem_addr <= selected pointer, o_mem_re pulses 1 cycle, state -> READ.
REQ-022 In READ on next i_en_bus_recv: o_nibble <= i_mem_rdata, o_nibble_valid pulses 1 cycle, selected pointer +1, state -> IDLE.
REQ-023 DP_WRITE accept: o_mem_addr <= dp, o_mem_wdata <= i_nibble, o_mem_we pulses 1 cycle, dp +1, state stays IDLE.
REQ-024 LOAD_PC/LOAD_DP accept: i_nibble captured as address bits [3:0], 3-bit counter <= 1, state -> LOAD.
REQ-025 In LOAD each i_en_bus_send SHALL capture i_nibble into bits [4k+3:4k] (k = counter), i_cmd_valid ignored; on k==4 the 20-bit value SHALL be written to the target pointer in that same edge and state -> IDLE.
REQ-026 Pointer increments SHALL wrap modulo 2^20 (FFFFF -> 00000) with no error.
REQ-027 i_cmd_valid & i_en_bus_send while busy (READ state): command ignored, o_bus_error <= 1; in LOAD it is treated as address data, not error.
REQ-028 Accepted illegal command (6, 7): no memory access, o_bus_error <= 1, state unchanged.
REQ-029 i_en_bus_send & i_en_bus_recv in same cycle: recv action SHALL execute; send-side acceptance blocked (state READ at edge counts as busy).
REQ-030 i_en_bus_recv in IDLE or LOAD SHALL have no effect.
REQ-031 o_bus_error SHALL clear only on reset.
REQ-032 Memory strobes SHALL never be asserted simultaneously.

Reset
REQ-033 On i_reset low, asynchronously: state IDLE, counter 0, o_pc_ptr = PC_RESET, o_dp_ptr = DP_RESET, all other outputs 0.
REQ-034 Reset during LOAD or READ SHALL discard partial address / pending read; no o_nibble_valid after release.
REQ-035 After release, first accept SHALL be possible on the first i_en_bus_send.

Verification
REQ-036 Reset release, PC_READ with mem[00000]=A -> o_mem_re addr 00000, next recv o_nibble=A valid 1 cycle, o_pc_ptr=00001.
REQ-037 LOAD_PC nibbles 5,4,3,2,1 over 5 sends -> o_pc_ptr=12345 after 5th send, o_busy high for exactly that span; then PC_READ addresses 12345.
REQ-038 LOAD_DP FFFFF, DP_WRITE 7, DP_WRITE 8 -> writes FFFFF=7, 00000=8, o_dp_ptr=00001.
REQ-039 PC_READ, then cmd_valid on next send before recv -> o_bus_error=1, second command ignored, first read completes normally.
REQ-040 i_cmd=6 accepted -> o_bus_error=1, no o_mem_re/o_mem_we, pointers unchanged; error persists until reset.
REQ-041 Reset asserted after 3rd LOAD_PC nibble -> o_pc_ptr=PC_RESET, state IDLE, o_busy=0 asynchronously.
